// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-PC sequencer for the 5-stage MIPS pipeline.
// Chooses each cycle between sequential fetch, a taken EX branch and an ID
// jump (J/JAL/JR), drives the IF/ID and ID/EX flush strobes, and traps
// misaligned JR targets to EXC_VECTOR.
// Optional build macro MIPS_DELAY_SLOT_EN: when defined, branch delay slots
// are honoured and the flush strobes are relaxed accordingly.

module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0080,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        br_taken_ex,
    input  logic [31:0] br_pc4_ex,
    input  logic [31:0] br_off_sh_ex,
    input  logic        jmp_id,
    input  logic        jmp_reg_id,
    input  logic [25:0] jmp_index_id,
    input  logic [31:0] jr_target_id,
    input  logic [31:0] pc4_id,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_valid_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o,
    output logic        addr_err_o,
    output logic [31:0] epc_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        TRAP
    } state_t;

    // With no boot delay requested, reset lands directly in RUN so the very
    // first cycle after reset releases is already fetching.
    localparam state_t     RESET_STATE = (BOOT_CYCLES == 0) ? RUN : BOOT;
    localparam logic [3:0] BOOT_LAST   = (BOOT_CYCLES == 0) ? 4'd0 : 4'(BOOT_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_addrErr;
    logic [3:0]  r_bootCnt;

    logic        w_running;
    logic        w_takeJump;
    logic        w_jrFault;
    logic [31:0] w_brTarget;
    logic [31:0] w_jTarget;
    logic        w_flushIfid;
    logic        w_flushIdex;

    assign w_running  = (r_state == RUN);
    assign w_brTarget = br_pc4_ex + br_off_sh_ex;
    assign w_jTarget  = jmp_reg_id ? jr_target_id : {pc4_id[31:28], jmp_index_id, 2'b00};
    assign w_takeJump = w_running && jmp_id && !stall_i && !br_taken_ex;
    assign w_jrFault  = w_takeJump && jmp_reg_id && (jr_target_id[1:0] != 2'b00);

    // Flush strobes follow the redirect chosen this cycle; only RUN can redirect.
    always_comb begin
        w_flushIfid = 1'b0;
        w_flushIdex = 1'b0;
        if (w_running) begin
`ifdef MIPS_DELAY_SLOT_EN
            w_flushIfid = br_taken_ex || w_jrFault;
            w_flushIdex = 1'b0;
`else
            w_flushIfid = br_taken_ex || w_takeJump;
            w_flushIdex = br_taken_ex;
`endif
        end
    end

    // Sequencer FSM: boot delay, next-PC selection by priority, one-cycle trap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RESET_STATE;
            r_pc      <= RESET_PC;
            r_epc     <= 32'h0000_0000;
            r_addrErr <= 1'b0;
            r_bootCnt <= 4'd0;
        end else begin
            r_addrErr <= 1'b0;
            case (r_state)
                BOOT: begin
                    if (r_bootCnt == BOOT_LAST) begin
                        r_state <= RUN;
                    end else begin
                        r_bootCnt <= r_bootCnt + 4'd1;
                    end
                end
                RUN: begin
                    if (br_taken_ex) begin
                        r_pc <= w_brTarget;
                    end else if (w_takeJump) begin
                        if (w_jrFault) begin
                            r_pc      <= EXC_VECTOR;
                            r_epc     <= pc4_id - 32'd4;
                            r_addrErr <= 1'b1;
                            r_state   <= TRAP;
                        end else begin
                            r_pc <= w_jTarget;
                        end
                    end else if (!stall_i) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                TRAP: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RESET_STATE;
                end
            endcase
        end
    end

    assign pc_o          = r_pc;
    assign pc_plus4_o    = r_pc + 32'd4;
    assign fetch_valid_o = w_running;
    assign flush_ifid_o  = w_flushIfid;
    assign flush_idex_o  = w_flushIdex;
    assign addr_err_o    = r_addrErr;
    assign epc_o         = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic checked against
// a behavioural model of the PC sequencing rules.

module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;
    localparam logic [31:0] EXC_TB      = 32'h0000_0080;
    localparam int          BOOT_TB     = 1;

`ifdef MIPS_DELAY_SLOT_EN
    localparam bit DSLOT = 1'b1;
`else
    localparam bit DSLOT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        br_taken_ex;
    logic [31:0] br_pc4_ex;
    logic [31:0] br_off_sh_ex;
    logic        jmp_id;
    logic        jmp_reg_id;
    logic [25:0] jmp_index_id;
    logic [31:0] jr_target_id;
    logic [31:0] pc4_id;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_valid_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
    logic        addr_err_o;
    logic [31:0] epc_o;

    int testsRun  = 0;
    int failCount = 0;

    pc_sequencer #(
        .RESET_PC   (RESET_PC_TB),
        .EXC_VECTOR (EXC_TB),
        .BOOT_CYCLES(BOOT_TB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .br_taken_ex  (br_taken_ex),
        .br_pc4_ex    (br_pc4_ex),
        .br_off_sh_ex (br_off_sh_ex),
        .jmp_id       (jmp_id),
        .jmp_reg_id   (jmp_reg_id),
        .jmp_index_id (jmp_index_id),
        .jr_target_id (jr_target_id),
        .pc4_id       (pc4_id),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .fetch_valid_o(fetch_valid_o),
        .flush_ifid_o (flush_ifid_o),
        .flush_idex_o (flush_idex_o),
        .addr_err_o   (addr_err_o),
        .epc_o        (epc_o)
    );

    always #5 clk = ~clk;

    // Reference model: architectural PC, EPC, error pulse, boot and trap tracking.
    logic [31:0] mPc;
    logic [31:0] mEpc;
    logic        mErr;
    int          mBootLeft;
    logic        mTrap;

    always @(posedge clk) begin
        if (reset) begin
            mPc       <= RESET_PC_TB;
            mEpc      <= 32'h0;
            mErr      <= 1'b0;
            mBootLeft <= BOOT_TB;
            mTrap     <= 1'b0;
        end else if (mBootLeft > 0) begin
            mBootLeft <= mBootLeft - 1;
            mErr      <= 1'b0;
        end else if (mTrap) begin
            mTrap <= 1'b0;
            mErr  <= 1'b0;
        end else begin
            mErr <= 1'b0;
            if (br_taken_ex) begin
                mPc <= br_pc4_ex + br_off_sh_ex;
            end else if (jmp_id && !stall_i) begin
                if (jmp_reg_id && (jr_target_id % 4 != 0)) begin
                    mPc   <= EXC_TB;
                    mEpc  <= pc4_id - 4;
                    mErr  <= 1'b1;
                    mTrap <= 1'b1;
                end else if (jmp_reg_id) begin
                    mPc <= jr_target_id;
                end else begin
                    mPc <= (pc4_id & 32'hF000_0000) | ({6'b0, jmp_index_id} << 2);
                end
            end else if (!stall_i) begin
                mPc <= mPc + 4;
            end
        end
    end

    task automatic setIdle();
        stall_i      = 1'b0;
        br_taken_ex  = 1'b0;
        br_pc4_ex    = 32'h0;
        br_off_sh_ex = 32'h0;
        jmp_id       = 1'b0;
        jmp_reg_id   = 1'b0;
        jmp_index_id = 26'h0;
        jr_target_id = 32'h0;
        pc4_id       = 32'h0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] expSeq [3];
        setIdle();
        reset       = 1'b1;
        br_taken_ex = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        testsRun++;
        if (pc_o !== RESET_PC_TB || fetch_valid_o !== 1'b0 || flush_ifid_o !== 1'b0 ||
            flush_idex_o !== 1'b0 || addr_err_o !== 1'b0 || epc_o !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL reset_state: pc=%h fv=%b fl=%b%b err=%b epc=%h, want pc=0 fv=0 fl=00 err=0 epc=0",
                     pc_o, fetch_valid_o, flush_ifid_o, flush_idex_o, addr_err_o, epc_o);
        end
        nextCycle();
        reset = 1'b0;
        setIdle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'h0 || fetch_valid_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL boot_cycle: pc=%h fv=%b, want pc=0 fv=0", pc_o, fetch_valid_o);
        end
        expSeq[0] = 32'h0;
        expSeq[1] = 32'h4;
        expSeq[2] = 32'h8;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            @(negedge clk);
            testsRun++;
            if (pc_o !== expSeq[i] || fetch_valid_o !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL run_step%0d: pc=%h fv=%b, want pc=%h fv=1", i, pc_o, fetch_valid_o, expSeq[i]);
            end
        end
        nextCycle();
    endtask

    task automatic test_branch();
        br_taken_ex  = 1'b1;
        br_pc4_ex    = 32'h0000_0100;
        br_off_sh_ex = 32'hFFFF_FFF0;
        @(negedge clk);
        testsRun++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== !DSLOT) begin
            failCount++;
            $display("[TB] FAIL branch_flush: ifid=%b idex=%b, want ifid=1 idex=%b", flush_ifid_o, flush_idex_o, !DSLOT);
        end
        nextCycle();
        setIdle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'h0000_00F0) begin
            failCount++;
            $display("[TB] FAIL branch_pc: pc=%h, want 000000f0", pc_o);
        end
        nextCycle();
    endtask

    task automatic test_priority();
        br_taken_ex  = 1'b1;
        br_pc4_ex    = 32'h0000_0100;
        br_off_sh_ex = 32'h0000_0100;
        jmp_id       = 1'b1;
        jmp_index_id = 26'h40;
        stall_i      = 1'b1;
        @(negedge clk);
        testsRun++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== !DSLOT) begin
            failCount++;
            $display("[TB] FAIL prio_flush: ifid=%b idex=%b, want ifid=1 idex=%b", flush_ifid_o, flush_idex_o, !DSLOT);
        end
        nextCycle();
        setIdle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'h0000_0200) begin
            failCount++;
            $display("[TB] FAIL prio_pc: pc=%h, want 00000200", pc_o);
        end
        nextCycle();
    endtask

    task automatic test_jump_stall();
        logic [31:0] heldPc;
        heldPc       = pc_o;
        stall_i      = 1'b1;
        jmp_id       = 1'b1;
        pc4_id       = 32'h1000_0010;
        jmp_index_id = 26'h3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            testsRun++;
            if (pc_o !== heldPc || flush_ifid_o !== 1'b0 || flush_idex_o !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL jstall_hold%0d: pc=%h fl=%b%b, want pc=%h fl=00", i, pc_o, flush_ifid_o, flush_idex_o, heldPc);
            end
            nextCycle();
        end
        stall_i = 1'b0;
        @(negedge clk);
        testsRun++;
        if (flush_ifid_o !== !DSLOT || flush_idex_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL jump_flush: ifid=%b idex=%b, want ifid=%b idex=0", flush_ifid_o, flush_idex_o, !DSLOT);
        end
        nextCycle();
        setIdle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'h1000_000C) begin
            failCount++;
            $display("[TB] FAIL jump_pc: pc=%h, want 1000000c", pc_o);
        end
        nextCycle();
    endtask

    task automatic test_jr_misaligned();
        jmp_id       = 1'b1;
        jmp_reg_id   = 1'b1;
        jr_target_id = 32'h0000_0402;
        pc4_id       = 32'h0000_0058;
        @(negedge clk);
        testsRun++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL jr_flush: ifid=%b idex=%b, want ifid=1 idex=0", flush_ifid_o, flush_idex_o);
        end
        nextCycle();
        setIdle();
        br_taken_ex = 1'b1;
        br_pc4_ex   = 32'h0000_4000;
        @(negedge clk);
        testsRun++;
        if (pc_o !== EXC_TB || addr_err_o !== 1'b1 || epc_o !== 32'h54 || fetch_valid_o !== 1'b0 ||
            flush_ifid_o !== 1'b0 || flush_idex_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL trap_cycle: pc=%h err=%b epc=%h fv=%b fl=%b%b, want pc=80 err=1 epc=54 fv=0 fl=00",
                     pc_o, addr_err_o, epc_o, fetch_valid_o, flush_ifid_o, flush_idex_o);
        end
        nextCycle();
        setIdle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== EXC_TB || addr_err_o !== 1'b0 || epc_o !== 32'h54 || fetch_valid_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL post_trap: pc=%h err=%b epc=%h fv=%b, want pc=80 err=0 epc=54 fv=1",
                     pc_o, addr_err_o, epc_o, fetch_valid_o);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'h84 || epc_o !== 32'h54) begin
            failCount++;
            $display("[TB] FAIL handler_step: pc=%h epc=%h, want pc=84 epc=54", pc_o, epc_o);
        end
        nextCycle();
    endtask

    task automatic test_wrap();
        br_taken_ex  = 1'b1;
        br_pc4_ex    = 32'hFFFF_FFF0;
        br_off_sh_ex = 32'h0000_000C;
        nextCycle();
        setIdle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL wrap_top: pc=%h pc4=%h, want fffffffc 00000000", pc_o, pc_plus4_o);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL wrap_pc: pc=%h, want 00000000", pc_o);
        end
        nextCycle();
    endtask

    task automatic test_back_to_back();
        br_taken_ex  = 1'b1;
        br_pc4_ex    = 32'h0000_0300;
        br_off_sh_ex = 32'h0000_0020;
        nextCycle();
        setIdle();
        jmp_id       = 1'b1;
        pc4_id       = 32'h2000_0000;
        jmp_index_id = 26'h10;
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'h320 || flush_ifid_o !== !DSLOT || flush_idex_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL b2b_branch: pc=%h ifid=%b idex=%b, want pc=320 ifid=%b idex=0",
                     pc_o, flush_ifid_o, flush_idex_o, !DSLOT);
        end
        nextCycle();
        setIdle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'h2000_0040) begin
            failCount++;
            $display("[TB] FAIL b2b_jump: pc=%h, want 20000040", pc_o);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (pc_o !== 32'h2000_0044) begin
            failCount++;
            $display("[TB] FAIL b2b_seq: pc=%h, want 20000044", pc_o);
        end
        nextCycle();
    endtask

    task automatic test_random();
        logic expFv;
        logic expIfid;
        logic expIdex;
        logic jrBad;
        for (int n = 0; n < 500; n++) begin
            reset        = ($urandom_range(0, 79) == 0);
            br_taken_ex  = ($urandom_range(0, 5) == 0);
            br_pc4_ex    = $urandom & 32'hFFFF_FFFC;
            br_off_sh_ex = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFC) : (32'hFFFF_F000 | ($urandom & 32'hFFC));
            jmp_id       = ($urandom_range(0, 2) == 0);
            jmp_reg_id   = $urandom_range(0, 1);
            jmp_index_id = 26'($urandom);
            jr_target_id = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            pc4_id       = $urandom & 32'hFFFF_FFFC;
            stall_i      = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            expFv   = (mBootLeft == 0) && !mTrap;
            jrBad   = jmp_id && !stall_i && !br_taken_ex && jmp_reg_id && (jr_target_id % 4 != 0);
            if (DSLOT) begin
                expIfid = expFv && (br_taken_ex || jrBad);
                expIdex = 1'b0;
            end else begin
                expIfid = expFv && (br_taken_ex || (jmp_id && !stall_i));
                expIdex = expFv && br_taken_ex;
            end
            testsRun++;
            if (pc_o !== mPc || pc_plus4_o !== mPc + 32'd4) begin
                failCount++;
                $display("[TB] FAIL rand_pc[%0d]: pc=%h pc4=%h, want pc=%h", n, pc_o, pc_plus4_o, mPc);
            end
            testsRun++;
            if (fetch_valid_o !== expFv) begin
                failCount++;
                $display("[TB] FAIL rand_fv[%0d]: fv=%b, want %b", n, fetch_valid_o, expFv);
            end
            testsRun++;
            if (flush_ifid_o !== expIfid || flush_idex_o !== expIdex) begin
                failCount++;
                $display("[TB] FAIL rand_flush[%0d]: ifid=%b idex=%b, want ifid=%b idex=%b",
                         n, flush_ifid_o, flush_idex_o, expIfid, expIdex);
            end
            testsRun++;
            if (addr_err_o !== mErr || epc_o !== mEpc) begin
                failCount++;
                $display("[TB] FAIL rand_err[%0d]: err=%b epc=%h, want err=%b epc=%h", n, addr_err_o, epc_o, mErr, mEpc);
            end
            nextCycle();
        end
        setIdle();
        reset = 1'b0;
    endtask

    // Directed scenarios first, then randomized traffic, then the summary.
    initial begin
        setIdle();
        reset = 1'b1;
        test_reset();
        test_branch();
        test_priority();
        test_jump_stall();
        test_jr_misaligned();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
